// File: rtl/core_seq_pkg.sv
// Shared encodings for the multi-cycle sequencer: FSM states, halt causes,
// one-hot access length bit positions and the base byte-write strobes.
package core_seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_MEM   = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd2;

  localparam int LEN_BYTE = 0;
  localparam int LEN_HALF = 1;
  localparam int LEN_WORD = 2;

  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;

  function automatic logic misaligned(input logic [2:0] len, input logic [1:0] off);
    return (len[LEN_WORD] && (off != 2'b00)) || (len[LEN_HALF] && off[0]);
  endfunction

endpackage

// File: rtl/core_sequencer_lsu_align.sv
// Load/store byte-lane alignment: store strobe/data shift into the lane at
// the address offset, load extract of byte/half with sign or zero extension.
module lsu_align
  import core_seq_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  len,
  input  logic        sext,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  we,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  logic [3:0]  base;
  logic [31:0] shifted;

  always_comb begin
    if (len[LEN_WORD])      base = STRB_WORD;
    else if (len[LEN_HALF]) base = STRB_HALF;
    else                    base = STRB_BYTE;
    we      = base << off;
    wdata   = store_data << {off, 3'b000};
    shifted = rdata >> {off, 3'b000};
    if (len[LEN_WORD])      ldata = rdata;
    else if (len[LEN_HALF]) ldata = {{16{sext & shifted[15]}}, shifted[15:0]};
    else                    ldata = {{24{sext & shifted[7]}}, shifted[7:0]};
  end

endmodule

// File: rtl/core_sequencer.sv
// Fetch/exec/mem/write-back sequencer around a single-cycle RV32I datapath.
// Optional performance counters are built only when SEQ_PERF_CNT_EN is defined.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] inst_q,
  output logic [31:0] pc_q,
  input  logic        dec_write_reg,
  input  logic        dec_write_reg_mux,
  input  logic        dec_write_mem,
  input  logic        dec_mem_signed_ext,
  input  logic [2:0]  dec_mem_len,
  input  logic        dec_illegal,
  input  logic [31:0] alu_addr,
  input  logic [31:0] store_data,
  input  logic [31:0] pc_next,
  output logic [31:0] load_data,
  output logic        reg_we,
  output logic        pc_we,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  state_t      state;
  logic        is_load, is_store, is_ldst, mis, retire;
  logic [3:0]  lsu_we;
  logic [31:0] lsu_wdata, lsu_ldata;

  assign is_load  = dec_write_reg & ~dec_write_reg_mux;
  assign is_store = dec_write_mem;
  assign is_ldst  = is_load | is_store;
  assign mis      = misaligned(dec_mem_len, alu_addr[1:0]);
  // Retire is decided on the edge that enters WB so the strobes are registered.
  assign retire   = ((state == S_EXEC) && !dec_illegal && !is_ldst) ||
                    ((state == S_MEM) && mem_req && mem_ack);

  lsu_align u_lsu (
    .off        (alu_addr[1:0]),
    .len        (dec_mem_len),
    .sext       (dec_mem_signed_ext),
    .store_data (store_data),
    .rdata      (mem_rdata),
    .we         (lsu_we),
    .wdata      (lsu_wdata),
    .ldata      (lsu_ldata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FETCH;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      load_data  <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= '0;
      mem_wdata  <= '0;
      reg_we     <= 1'b0;
      pc_we      <= 1'b0;
      halted     <= 1'b0;
      halt_cause <= CAUSE_NONE;
    end else begin
      reg_we <= retire & dec_write_reg;
      pc_we  <= retire;
      case (state)
        S_FETCH: begin
          // First fetch after reset raises the request here; later fetches are raised in WB.
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= pc_q;
          end else if (mem_ack) begin
            inst_q   <= mem_rdata;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (dec_illegal) begin
            state      <= S_HALT;
            halted     <= 1'b1;
            halt_cause <= CAUSE_ILLEGAL;
          end else if (is_ldst && mis) begin
            state      <= S_HALT;
            halted     <= 1'b1;
            halt_cause <= CAUSE_MISALIGN;
          end else if (is_ldst) begin
            state     <= S_MEM;
            mem_req   <= 1'b1;
            mem_addr  <= {alu_addr[31:2], 2'b00};
            mem_we    <= is_store ? lsu_we : 4'b0000;
            mem_wdata <= is_store ? lsu_wdata : 32'h0;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_req && mem_ack) begin
            if (is_load) load_data <= lsu_ldata;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= '0;
            mem_wdata <= '0;
            state     <= S_WB;
          end
        end
        S_WB: begin
          pc_q     <= pc_next;
          mem_req  <= 1'b1;
          mem_addr <= pc_next;
          state    <= S_FETCH;
        end
        S_HALT: ;
        default: begin
          state      <= S_HALT;
          halted     <= 1'b1;
          halt_cause <= CAUSE_ILLEGAL;
        end
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: the bench plays decoder, datapath
// and memory, and predicts every bus cycle, strobe and load result.
module tb_core_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk, rst;
  logic        mem_req, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;
  logic [31:0] inst_q, pc_q, alu_addr, store_data, pc_next, load_data;
  logic        dec_write_reg, dec_write_reg_mux, dec_write_mem, dec_mem_signed_ext, dec_illegal;
  logic [2:0]  dec_mem_len;
  logic        reg_we, pc_we, halted;
  logic [1:0]  halt_cause;
  logic [31:0] cycle_cnt, instret_cnt;

  core_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst_q(inst_q), .pc_q(pc_q),
    .dec_write_reg(dec_write_reg), .dec_write_reg_mux(dec_write_reg_mux),
    .dec_write_mem(dec_write_mem), .dec_mem_signed_ext(dec_mem_signed_ext),
    .dec_mem_len(dec_mem_len), .dec_illegal(dec_illegal),
    .alu_addr(alu_addr), .store_data(store_data), .pc_next(pc_next),
    .load_data(load_data), .reg_we(reg_we), .pc_we(pc_we),
    .halted(halted), .halt_cause(halt_cause),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word, addr, sdata, nxt, rd;
    logic        wr, mux, wm, sext, ill;
    logic [2:0]  len;
  } inst_t;

  int          checks = 0, errors = 0;
  int          cyc_m = 0, inst_m = 0;
  logic [31:0] pc_m = RESET_PC;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) cyc_m++;
    #1;
  endtask

  task automatic chk_cnt();
`ifdef SEQ_PERF_CNT_EN
    chk("cycle_cnt", cycle_cnt, cyc_m);
    chk("instret_cnt", instret_cnt, inst_m);
`else
    chk("cycle_cnt_off", cycle_cnt, 32'h0);
    chk("instret_cnt_off", instret_cnt, 32'h0);
`endif
  endtask

  function automatic int nbytes(input logic [2:0] len);
    return len[2] ? 4 : (len[1] ? 2 : 1);
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [2:0] len,
                                           input logic sx, input logic [1:0] o);
    longint v, span;
    if (len[2]) return rd;
    span = longint'(1) << (8 * nbytes(len));
    v = longint'(rd >> (8 * o)) % span;
    if (sx && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  task automatic do_reset();
    rst = 1'b1; mem_ack = 1'b0;
    tick(); tick();
    chk("rst_req", mem_req, 0);     chk("rst_addr", mem_addr, 0);
    chk("rst_we", mem_we, 0);       chk("rst_wdata", mem_wdata, 0);
    chk("rst_reg_we", reg_we, 0);   chk("rst_pc_we", pc_we, 0);
    chk("rst_halted", halted, 0);   chk("rst_cause", halt_cause, 0);
    chk("rst_pc", pc_q, RESET_PC);  chk("rst_ir", inst_q, 0);
    chk("rst_ld", load_data, 0);
    cyc_m = 0; inst_m = 0; pc_m = RESET_PC;
    chk_cnt();
    rst = 1'b0;
    chk("idle_req", mem_req, 0);
    tick();
  endtask

  // Entered in the fetch cycle; returns in the next fetch cycle or after halting.
  task automatic do_inst(input inst_t d, input int wf, input int wm, output bit hlt);
    bit ld, st, ldst, mis;
    int nb;
    hlt = 0;
    dec_write_reg = d.wr; dec_write_reg_mux = d.mux; dec_write_mem = d.wm;
    dec_mem_signed_ext = d.sext; dec_mem_len = d.len; dec_illegal = d.ill;
    alu_addr = d.addr; store_data = d.sdata; pc_next = d.nxt;
    chk("fetch_req", mem_req, 1); chk("fetch_addr", mem_addr, pc_m); chk("fetch_we", mem_we, 0);
    mem_ack = 1'b0;
    for (int i = 0; i < wf; i++) begin
      tick();
      chk("fetch_hold_req", mem_req, 1); chk("fetch_hold_addr", mem_addr, pc_m);
    end
    mem_ack = 1'b1; mem_rdata = d.word;
    tick();
    mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
    chk("ir", inst_q, d.word); chk("exec_req", mem_req, 0);
    chk("exec_pc_we", pc_we, 0);
    ld = d.wr && !d.mux; st = d.wm; ldst = ld || st;
    nb = nbytes(d.len);
    mis = (d.addr % nb) != 0;
    tick();
    if (d.ill || (ldst && mis)) begin
      hlt = 1;
      for (int i = 0; i < 3; i++) begin
        chk("halt_flag", halted, 1);
        chk("halt_cause", halt_cause, d.ill ? 32'd1 : 32'd2);
        chk("halt_req", mem_req, 0); chk("halt_pc_we", pc_we, 0); chk("halt_reg_we", reg_we, 0);
        chk_cnt();
        mem_ack = 1'($urandom % 2);
        tick();
      end
      return;
    end
    if (ldst) begin
      mem_ack = 1'b0;
      for (int i = 0; i <= wm; i++) begin
        chk("mem_req", mem_req, 1);
        chk("mem_addr", mem_addr, d.addr & 32'hFFFF_FFFC);
        chk("mem_we", mem_we, st ? (((32'd1 << nb) - 1) << d.addr[1:0]) : 32'd0);
        if (st) chk("mem_wdata", mem_wdata, d.sdata << (8 * d.addr[1:0]));
        chk("mem_pc_we", pc_we, 0);
        if (i < wm) tick();
      end
      mem_ack = 1'b1; mem_rdata = d.rd;
      tick();
      mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
      if (ld) chk("load_data", load_data, exp_load(d.rd, d.len, d.sext, d.addr[1:0]));
    end
    inst_m++;
    chk("wb_reg_we", reg_we, d.wr); chk("wb_pc_we", pc_we, 1); chk("wb_req", mem_req, 0);
    chk_cnt();
    tick();
    pc_m = d.nxt;
    chk("pc", pc_q, pc_m); chk("post_wb_pc_we", pc_we, 0); chk("post_wb_reg_we", reg_we, 0);
  endtask

  function automatic inst_t mk(input logic wr, mux, wm, sx, input logic [2:0] len,
                               input logic [31:0] addr, sdata, rd, nxt);
    inst_t d;
    d.word = $urandom; d.wr = wr; d.mux = mux; d.wm = wm; d.sext = sx; d.ill = 1'b0;
    d.len = len; d.addr = addr; d.sdata = sdata; d.rd = rd; d.nxt = nxt;
    return d;
  endfunction

  function automatic inst_t rand_inst(input logic [31:0] pc);
    inst_t d;
    int k;
    logic [31:0] r;
    k = $urandom % 16;
    d = mk(1'b0, 1'b0, 1'b0, 1'($urandom % 2), 3'(1 << ($urandom % 3)),
           $urandom, $urandom, $urandom, pc + 32'd4);
    d.ill = (k == 0);
    if (k <= 5)       begin d.wr = 1'b1; d.mux = 1'b1; end
    else if (k <= 9)  begin d.wr = 1'b1; d.mux = 1'b0; end
    else if (k <= 13) d.wm = 1'b1;
    if ($urandom % 8 != 0) d.addr = d.addr - (d.addr % nbytes(d.len));
    if ($urandom % 4 == 0) begin r = $urandom; d.nxt = r & 32'hFFFF_FFFC; end
    return d;
  endfunction

  initial begin
    bit h;
    inst_t d;
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    dec_write_reg = 0; dec_write_reg_mux = 0; dec_write_mem = 0; dec_mem_signed_ext = 0;
    dec_mem_len = 3'b100; dec_illegal = 0; alu_addr = 0; store_data = 0; pc_next = 0;

    do_reset();
    for (int i = 0; i < 10; i++) begin
      d = mk(1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 32'h0, 32'h0, 32'h0, pc_m + 32'd4);
      d.word = 32'h0010_0093;
      do_inst(d, 0, 0, h);
    end
    chk("ten_pc", pc_q, 32'd40);
`ifdef SEQ_PERF_CNT_EN
    chk("ten_instret", instret_cnt, 32'd10);
    chk("ten_cycles_plus1", cycle_cnt, 32'd31);
`endif

    // sb into the top byte lane
    do_inst(mk(1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 32'h103, 32'h0000_00A5, 32'h0, pc_m + 4), 0, 0, h);
    // lh / lhu from the upper half
    do_inst(mk(1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 32'h202, 32'h0, 32'h8001_1234, pc_m + 4), 1, 2, h);
    chk("lh_value", load_data, 32'hFFFF_8001);
    do_inst(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 32'h202, 32'h0, 32'h8001_1234, pc_m + 4), 0, 1, h);
    chk("lhu_value", load_data, 32'h0000_8001);
    // misaligned lw halts
    do_inst(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 32'h201, 32'h0, 32'h0, pc_m + 4), 0, 0, h);
    chk("lw_mis_halted", {31'd0, h}, 1);
    chk("lw_mis_load_kept", load_data, 32'h0000_8001);

    // Async reset on the second wait cycle of a fetch
    do_reset();
    do_inst(mk(1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 32'h0, 32'h0, 32'h0, 32'h0000_0040), 0, 0, h);
    mem_ack = 1'b0;
    tick(); tick();
    chk("pre_arst_req", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", mem_req, 0); chk("arst_pc", pc_q, RESET_PC); chk("arst_addr", mem_addr, 0);
    rst = 1'b0;
    cyc_m = 0; inst_m = 0; pc_m = RESET_PC;
    tick();
    do_inst(mk(1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 32'h0, 32'h0, 32'h0, 32'h4), 3, 0, h);

    // Randomized programs, restarting from reset after every halt
    for (int n = 0; n < 400; n++) begin
      do_inst(rand_inst(pc_m), $urandom % 4, $urandom % 4, h);
      if (h) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM that turns the single-cycle RV32I decode/execute datapath into a fetch/execute/memory/write-back machine sharing one memory port. It owns the PC and the instruction register, feeds the instruction to the decoder, and sequences the memory handshake for fetches, loads and stores. It strobes the register-file and PC writes once per retired instruction. It also performs load/store byte-lane alignment and halts on illegal or misaligned instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock. All state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  out  1  memory request. Held until mem_ack.
- mem_addr  out  32  word-aligned address: PC for fetch, {alu_addr[31:2],2'b00} for data.
- mem_we  out  4  byte write strobes. 0 for fetch and load.
- mem_wdata  out  32  store data shifted to its byte lane.
- mem_ack  in  1  request accepted and completed. mem_rdata is valid in the same cycle.
- mem_rdata  in  32  read data.
- inst_q  out  32  instruction register, drives the decoder.
- pc_q  out  32  current PC.
- dec_write_reg, dec_write_reg_mux, dec_write_mem, dec_mem_signed_ext  in  1 each  decoder controls.
- dec_mem_len  in  3  one-hot {word,half,byte}.
- dec_illegal  in  1  no decoded instruction matched.
- alu_addr  in  32  effective address from the ALU.
- store_data  in  32  rs2 value.
- pc_next  in  32  next PC chosen by the datapath (pc+4 or target).
- load_data  out  32  aligned and extended load result, held until the next load.
- reg_we  out  1  register-file write strobe, 1-cycle pulse.
- pc_we  out  1  retire pulse, 1 cycle.
- halted  out  1  sticky halt.
- halt_cause  out  2  0 none, 1 illegal, 2 misaligned.
- cycle_cnt, instret_cnt  out  32 each  performance counters (see Configuration).

## Operation
- States: FETCH, EXEC, MEM, WB, HALT.
- FETCH:
  - mem_req=1, mem_addr=pc_q, mem_we=0.
  - On mem_ack: inst_q<=mem_rdata, go to EXEC.
- EXEC: one settle cycle, no request. Checks in priority order:
  1. dec_illegal -> HALT, cause 1.
  2. Load (dec_write_reg & ~dec_write_reg_mux) or store (dec_write_mem) with a misaligned address -> HALT, cause 2. Misaligned means word access with alu_addr[1:0]!=0, or half access with alu_addr[0]=1.
  3. Load or store -> MEM.
  4. Otherwise -> WB.
- MEM:
  - mem_req=1.
  - Stores: mem_we = base strobe (word 1111, half 0011, byte 0001) << alu_addr[1:0]; mem_wdata = store_data << 8*alu_addr[1:0].
  - On mem_ack with a load: take the byte or half at offset alu_addr[1:0], sign-extend if dec_mem_signed_ext else zero-extend, write it to load_data. Then go to WB.
- WB: reg_we=dec_write_reg, pc_we=1, pc_q<=pc_next, go to FETCH.
- HALT: absorbing, all strobes 0, halted=1. Exits only on rst.
- Memory outputs are 0 whenever mem_req=0.

## Timing
- Reset values: state FETCH, pc_q=RESET_PC, inst_q=0, load_data=0, and all of the following 0: mem_req, mem_we, mem_wdata, mem_addr, reg_we, pc_we, halted, halt_cause, counters.
- Reset asserted mid-request drops mem_req immediately (asynchronous reset). The first request is in the first clock after rst deasserts.
- mem_ack may arrive in the same cycle as the request. mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ack=0. mem_ack seen while mem_req=0 is ignored.
- Latency with zero-wait memory: 3 cycles for non-memory instructions, 4 cycles for loads and stores. Each wait cycle adds 1.
- Exactly one reg_we/pc_we pulse per retired instruction. Both are 0 on any halt.

## Configuration
- SEQ_PERF_CNT_EN defined:
  - cycle_cnt increments every cycle out of reset, including while halted.
  - instret_cnt increments on each pc_we.
  - Both wrap modulo 2^32.
- SEQ_PERF_CNT_EN undefined: both outputs are constant 0 and no counter flops are built. Ports stay present.

## Structure
- core_seq_pkg holds:
  - state encoding (3-bit),
  - halt_cause constants,
  - mem_len bit positions,
  - the base strobe constants.
- Sub-module lsu_align (combinational): store strobe/data shift and load extract/extend. It is instantiated once.
- The FSM, PC, IR and counters live in core_sequencer.

## Test plan
- Reset, then addi fetched with ack in the same cycle -> mem_req in cycle 1, reg_we pulse in cycle 3, pc_q 0->4.
- sb store_data=32'h0000_00A5, alu_addr=32'h103 -> mem_addr 32'h100, mem_we 4'b1000, mem_wdata 32'hA500_0000, reg_we=0.
- lh signed, alu_addr=32'h202, mem_rdata=32'h8001_1234 -> load_data 32'hFFFF_8001. Same with lhu -> 32'h0000_8001.
- lw with alu_addr=32'h201 -> HALT, halt_cause 2, no further mem_req, no pc_we.
- Fetch with ack delayed 3 cycles, rst pulsed on the 2nd wait cycle -> mem_req falls asynchronously, pc_q=RESET_PC, fetch restarts.
- With SEQ_PERF_CNT_EN, 10 addi instructions with zero-wait memory -> instret_cnt=10, cycle_cnt=30 after the tenth retire.
